// File: rtl/envase_parametrizado_if.sv
// Bundle of the bottling-station operator/sensor inputs and the
// actuator/status/counter outputs.
//   master : drives start, garrafa, sensor_de_nivel, cq_valido, cq_ok,
//            add_estoque; observes everything else
//   slave  : the station controller itself
interface envase_parametrizado_if #(
  parameter int unsigned W = 8
);
  logic         start;
  logic         garrafa;
  logic         sensor_de_nivel;
  logic         cq_valido;
  logic         cq_ok;
  logic         add_estoque;

  logic         motor;
  logic         ev;
  logic         ve;
  logic         descarte;
  logic         estaemcq;
  logic         disp;
  logic         alarme;
  logic         falha;
  logic         lote_pronto;
  logic [W-1:0] rolhas_estoque;
  logic [W-1:0] rolhas_linha;
  logic [W-1:0] garrafas;
  logic [W-1:0] lotes;

  modport master (
    output start, garrafa, sensor_de_nivel, cq_valido, cq_ok, add_estoque,
    input  motor, ev, ve, descarte, estaemcq, disp, alarme, falha,
           lote_pronto, rolhas_estoque, rolhas_linha, garrafas, lotes
  );

  modport slave (
    input  start, garrafa, sensor_de_nivel, cq_valido, cq_ok, add_estoque,
    output motor, ev, ve, descarte, estaemcq, disp, alarme, falha,
           lote_pronto, rolhas_estoque, rolhas_linha, garrafas, lotes
  );
endinterface

// File: rtl/envase_parametrizado.sv
// Parametrised bottling-station controller: line sequencer (transport,
// fill, seal, quality check, discard), cork stock/line dispenser and
// bottle/batch counters.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : envase_parametrizado_if.slave (sensor/operator inputs,
//           Moore actuator outputs, status flags, W-bit counters)
module envase_parametrizado #(
  parameter int unsigned W            = 8,
  parameter int unsigned LOTE         = 12,
  parameter int unsigned MAX_LOTES    = 10,
  parameter int unsigned LINHA_CAP    = 5,
  parameter int unsigned ESTQ_INICIAL = 20,
  parameter int unsigned RECARGA      = 10,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  envase_parametrizado_if.slave  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [3:0] {
    PARADO,
    TRANSPORTE,
    ENCHENDO,
    AGUARDA_ROLHA,
    VEDANDO,
    CQ,
    DESCARTE,
    CONTANDO,
    FALHA
  } estado_t;

  estado_t        r_estado;
  estado_t        w_prox;
  logic [TW-1:0]  r_timer;
  logic [W-1:0]   r_estoque;
  logic [W-1:0]   r_linha;
  logic [W-1:0]   r_garrafas;
  logic [W-1:0]   r_lotes;

  logic           w_disp;
  logic           w_selo;
  logic           w_conta;
  logic           w_fim_lote;
  logic [W:0]     w_soma;
  logic [W-1:0]   w_estoque_prox;
  logic [W-1:0]   w_linha_prox;

  // Dispenser runs regardless of the sequencer, but is held off in reset.
  assign w_disp     = reset && (r_linha < W'(LINHA_CAP)) && (r_estoque != '0);
  assign w_selo     = (r_estado == VEDANDO) && (r_linha != '0);
  assign w_conta    = (r_estado == CONTANDO);
  assign w_fim_lote = w_conta && (r_garrafas == W'(LOTE - 1));

  // One extra bit catches overflow of stock + restock (RECARGA < 2^W).
  assign w_soma = {1'b0, r_estoque} + (W+1)'(RECARGA) - (W+1)'(w_disp);

  always_comb begin
    w_estoque_prox = r_estoque;
    if (bus.add_estoque) begin
      w_estoque_prox = w_soma[W] ? '1 : w_soma[W-1:0];
    end else if (w_disp) begin
      w_estoque_prox = r_estoque - W'(1);
    end
  end

  // A cork entering and a cork leaving in the same cycle cancel out.
  always_comb begin
    w_linha_prox = r_linha;
    if (w_disp && !w_selo) begin
      w_linha_prox = r_linha + W'(1);
    end else if (w_selo && !w_disp) begin
      w_linha_prox = r_linha - W'(1);
    end
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      PARADO:        if (bus.start) w_prox = TRANSPORTE;
      TRANSPORTE: begin
        if (!bus.start)       w_prox = PARADO;
        else if (bus.garrafa) w_prox = ENCHENDO;
      end
      ENCHENDO: begin
        // Level sensor wins over a timeout landing on the same cycle.
        if (bus.sensor_de_nivel)
          w_prox = (r_linha != '0) ? VEDANDO : AGUARDA_ROLHA;
        else if (r_timer == TW'(TIMEOUT - 1))
          w_prox = FALHA;
      end
      AGUARDA_ROLHA: if (r_linha != '0) w_prox = VEDANDO;
      VEDANDO:       w_prox = CQ;
      CQ:            if (bus.cq_valido) w_prox = bus.cq_ok ? CONTANDO : DESCARTE;
      DESCARTE:      w_prox = TRANSPORTE;
      CONTANDO:      w_prox = TRANSPORTE;
      FALHA:         if (!bus.start) w_prox = PARADO;
      default:       w_prox = PARADO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_estado   <= PARADO;
      r_timer    <= '0;
      r_estoque  <= W'(ESTQ_INICIAL);
      r_linha    <= '0;
      r_garrafas <= '0;
      r_lotes    <= '0;
    end else begin
      r_estado  <= w_prox;
      r_timer   <= (r_estado == ENCHENDO) ? r_timer + TW'(1) : '0;
      r_estoque <= w_estoque_prox;
      r_linha   <= w_linha_prox;
      if (w_conta) begin
        if (w_fim_lote) begin
          r_garrafas <= '0;
          r_lotes    <= (r_lotes == W'(MAX_LOTES - 1)) ? '0 : r_lotes + W'(1);
        end else begin
          r_garrafas <= r_garrafas + W'(1);
        end
      end
    end
  end

  assign bus.motor          = (r_estado == TRANSPORTE);
  assign bus.ev             = (r_estado == ENCHENDO);
  assign bus.ve             = (r_estado == VEDANDO);
  assign bus.descarte       = (r_estado == DESCARTE);
  assign bus.estaemcq       = (r_estado == CQ);
  assign bus.falha          = (r_estado == FALHA);
  assign bus.alarme         = (r_estado == AGUARDA_ROLHA) && (r_estoque == '0);
  assign bus.disp           = w_disp;
  assign bus.lote_pronto    = w_fim_lote;
  assign bus.rolhas_estoque = r_estoque;
  assign bus.rolhas_linha   = r_linha;
  assign bus.garrafas       = r_garrafas;
  assign bus.lotes          = r_lotes;

endmodule

// File: tb/tb_envase_parametrizado.sv
module tb_envase_parametrizado;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  envase_parametrizado_if #(.W(8)) m_if ();
  envase_parametrizado_if #(.W(8)) s_if ();

  envase_parametrizado #(
    .W(8), .LOTE(12), .MAX_LOTES(10), .LINHA_CAP(5),
    .ESTQ_INICIAL(20), .RECARGA(10), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(m_if)
  );

  // Empty-stock variant with a large restock, used for the
  // seal + dispense + saturating-restock corner.
  envase_parametrizado #(
    .W(8), .LOTE(12), .MAX_LOTES(10), .LINHA_CAP(5),
    .ESTQ_INICIAL(0), .RECARGA(126), .TIMEOUT(16)
  ) dut_sat (
    .clk(clk), .reset(reset), .bus(s_if)
  );

  typedef struct {
    bit         disc;
    bit         lp;
    logic [7:0] g;
    logic [7:0] l;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_g    = 0;
  int   exp_l    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return m_if.motor;
      default: return m_if.estaemcq;
    endcase
  endfunction

  task automatic wait_for(input int which, input int limit, input string name);
    int n = 0;
    checks++;
    while (sig(which) !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > limit) begin
        failures++;
        $display("FAIL %s: still low after %0d cycles, expected high", name, limit);
        return;
      end
    end
  endtask

  task automatic fill_phase(input bit hold, input bit expect_wait);
    wait_for(0, 20, "wait_motor");
    m_if.garrafa = 1'b1;
    @(negedge clk);
    m_if.garrafa = 1'b0;
    chk("fill_ev", m_if.ev, 1);
    if (!hold) begin
      m_if.sensor_de_nivel = 1'b1;
      @(negedge clk);
      m_if.sensor_de_nivel = 1'b0;
      if (expect_wait) begin
        chk("wait_alarme", m_if.alarme, 1);
        chk("wait_ve", m_if.ve, 0);
      end else begin
        chk("seal_ve", m_if.ve, 1);
      end
    end
  endtask

  task automatic finish_phase(input bit ok);
    exp_t e;
    wait_for(1, 20, "wait_cq");
    m_if.cq_valido = 1'b1;
    m_if.cq_ok     = ok;
    e.disc = !ok;
    e.lp   = 1'b0;
    if (ok) begin
      if (exp_g == 11) begin
        e.lp  = 1'b1;
        exp_g = 0;
        exp_l = (exp_l == 9) ? 0 : exp_l + 1;
      end else begin
        exp_g++;
      end
    end
    e.g = 8'(exp_g);
    e.l = 8'(exp_l);
    sbq.push_back(e);
    @(negedge clk);
    m_if.cq_valido = 1'b0;
    m_if.cq_ok     = 1'b0;
  endtask

  // Monitor: a bottle result is the cycle right after CQ ends; the
  // counters are compared one cycle later, back in TRANSPORTE.
  initial begin : monitor
    bit   prev_cq = 1'b0;
    bit   pend    = 1'b0;
    bit   c_desc  = 1'b0;
    bit   c_lp    = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: bottle result with empty queue, expected none");
        end else begin
          e = sbq.pop_front();
          chk("res_descarte", c_desc, e.disc);
          chk("res_lote_pronto", c_lp, e.lp);
          chk("res_garrafas", m_if.garrafas, e.g);
          chk("res_lotes", m_if.lotes, e.l);
          chk("res_descarte_one_cycle", m_if.descarte, 0);
          chk("res_back_to_transporte", m_if.motor, 1);
        end
      end
      if (prev_cq && !m_if.estaemcq) begin
        c_desc = m_if.descarte;
        c_lp   = m_if.lote_pronto;
        pend   = 1'b1;
      end
      prev_cq = m_if.estaemcq;
    end
  end

  initial begin : watchdog
    repeat (20000) @(negedge clk);
    failures++;
    $display("FAIL watchdog: run did not complete, expected completion within 20000 cycles");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    reset = 1'b0;
    m_if.start = 0; m_if.garrafa = 0; m_if.sensor_de_nivel = 0;
    m_if.cq_valido = 0; m_if.cq_ok = 0; m_if.add_estoque = 0;
    s_if.start = 0; s_if.garrafa = 0; s_if.sensor_de_nivel = 0;
    s_if.cq_valido = 0; s_if.cq_ok = 0; s_if.add_estoque = 0;

    repeat (3) @(negedge clk);
    chk("rst_estoque", m_if.rolhas_estoque, 20);
    chk("rst_linha", m_if.rolhas_linha, 0);
    chk("rst_garrafas", m_if.garrafas, 0);
    chk("rst_lotes", m_if.lotes, 0);
    chk("rst_disp", m_if.disp, 0);
    chk("rst_motor", m_if.motor, 0);
    chk("rst_falha", m_if.falha, 0);
    chk("rst_sat_estoque", s_if.rolhas_estoque, 0);

    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("fill_line_linha", m_if.rolhas_linha, 5);
    chk("fill_line_estoque", m_if.rolhas_estoque, 15);
    chk("fill_line_disp_off", m_if.disp, 0);

    // 20 bottles (13th rejected) consume all 20 corks.
    m_if.start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fill_phase(1'b0, 1'b0);
      finish_phase(i != 12);
    end

    // 21st bottle finds no cork anywhere.
    fill_phase(1'b0, 1'b1);
    chk("empty_estoque", m_if.rolhas_estoque, 0);
    chk("empty_linha", m_if.rolhas_linha, 0);
    m_if.add_estoque = 1'b1;
    @(negedge clk);
    m_if.add_estoque = 1'b0;
    chk("restock_estoque", m_if.rolhas_estoque, 10);
    chk("restock_disp", m_if.disp, 1);
    chk("restock_alarme_off", m_if.alarme, 0);
    chk("restock_ve_wait", m_if.ve, 0);
    @(negedge clk);
    chk("restock_linha1", m_if.rolhas_linha, 1);
    chk("restock_estoque9", m_if.rolhas_estoque, 9);
    chk("restock_still_wait", m_if.ve, 0);
    @(negedge clk);
    chk("restock_seal", m_if.ve, 1);
    finish_phase(1'b1);

    for (int i = 0; i < 11; i++) begin
      m_if.add_estoque = 1'b1;
      @(negedge clk);
      m_if.add_estoque = 1'b0;
      @(negedge clk);
    end

    // 100 more good bottles bring the batch counter round to 0.
    for (int i = 0; i < 100; i++) begin
      fill_phase(1'b0, 1'b0);
      finish_phase(1'b1);
    end
    @(negedge clk);
    chk("wrap_lotes", m_if.lotes, 0);
    chk("wrap_garrafas", m_if.garrafas, 0);

    // Fill timeout.
    fill_phase(1'b1, 1'b0);
    n = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m_if.ev === 1'b1) n++;
      else break;
    end
    chk("timeout_ev_cycles", n, 16);
    chk("timeout_falha", m_if.falha, 1);
    chk("timeout_motor", m_if.motor, 0);
    m_if.garrafa = 1'b1;
    repeat (3) @(negedge clk);
    m_if.garrafa = 1'b0;
    chk("falha_sticky", m_if.falha, 1);
    chk("falha_motor_off", m_if.motor, 0);
    m_if.start = 1'b0;
    @(negedge clk);
    chk("falha_clear", m_if.falha, 0);
    chk("falha_to_parado", m_if.motor, 0);
    m_if.start = 1'b1;
    @(negedge clk);
    chk("restart_motor", m_if.motor, 1);

    fill_phase(1'b0, 1'b0);
    finish_phase(1'b1);
    @(negedge clk);

    // Reset in the middle of operation beats a restock on the same edge.
    reset = 1'b0;
    m_if.add_estoque = 1'b1;
    @(negedge clk);
    chk("midrst_estoque", m_if.rolhas_estoque, 20);
    chk("midrst_linha", m_if.rolhas_linha, 0);
    chk("midrst_garrafas", m_if.garrafas, 0);
    chk("midrst_disp", m_if.disp, 0);
    chk("midrst_motor", m_if.motor, 0);
    m_if.add_estoque = 1'b0;
    m_if.start = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // Seal + dispense + restock on the same edge, stock saturating.
    s_if.start = 1'b1;
    @(negedge clk);
    chk("sat_motor", s_if.motor, 1);
    s_if.garrafa = 1'b1;
    @(negedge clk);
    s_if.garrafa = 1'b0;
    chk("sat_ev", s_if.ev, 1);
    s_if.sensor_de_nivel = 1'b1;
    @(negedge clk);
    s_if.sensor_de_nivel = 1'b0;
    chk("sat_alarme", s_if.alarme, 1);
    s_if.add_estoque = 1'b1;
    @(negedge clk);
    s_if.add_estoque = 1'b0;
    chk("sat_estoque126", s_if.rolhas_estoque, 126);
    @(negedge clk);
    chk("sat_linha1", s_if.rolhas_linha, 1);
    chk("sat_estoque125", s_if.rolhas_estoque, 125);
    s_if.add_estoque = 1'b1;
    @(negedge clk);
    chk("sat_ve", s_if.ve, 1);
    chk("sat_estoque250", s_if.rolhas_estoque, 250);
    chk("sat_linha2", s_if.rolhas_linha, 2);
    chk("sat_disp", s_if.disp, 1);
    @(negedge clk);
    s_if.add_estoque = 1'b0;
    chk("sat_estoque255", s_if.rolhas_estoque, 255);
    chk("sat_linha_same", s_if.rolhas_linha, 2);
    chk("sat_cq", s_if.estaemcq, 1);

    repeat (2) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/envase_parametrizado.md
# envase_parametrizado

Parametrised bottling-station controller; next generation of the single-line bottling top level. It integrates the line sequencer (transport, fill, seal, quality check, discard), the cork stock/line dispenser and the bottle/batch counters in one block, with configurable batch size, batch wrap, line capacity, restock amount and a fill-timeout fault the previous generation lacks. Counters feed the existing decimal display drivers; the block sits directly under the board top level.

## Interface
- W, 8: width of all counters
- LOTE, 12: bottles per batch (2..2^W-1)
- MAX_LOTES, 10: batch count wraps to 0 on reaching this value
- LINHA_CAP, 5: corks held on the sealing line
- ESTQ_INICIAL, 20: cork stock after reset
- RECARGA, 10: corks added per restock pulse
- TIMEOUT, 16: max cycles in fill before fault (≥2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- start  in  1  level; 1 = run, 0 = stop after current bottle
- garrafa  in  1  bottle at fill position
- sensor_de_nivel  in  1  fill level reached
- cq_valido  in  1  quality-check result strobe
- cq_ok  in  1  quality result, sampled with cq_valido
- add_estoque  in  1  one-cycle restock pulse
- motor, ev, ve, descarte  out  1  conveyor, fill valve, sealer, discard actuator
- estaemcq  out  1  bottle at quality check
- disp  out  1  dispenser moving a cork this cycle
- alarme  out  1  waiting for cork with stock empty
- falha  out  1  fill timeout fault
- lote_pronto  out  1  one-cycle pulse, batch completed
- rolhas_estoque, rolhas_linha, garrafas, lotes  out  W  counters

## Operation
- States: PARADO, TRANSPORTE, ENCHENDO, AGUARDA_ROLHA, VEDANDO, CQ, DESCARTE, CONTANDO, FALHA. Moore outputs decoded from state register.
- PARADO: all actuators 0; start=1 → TRANSPORTE.
- TRANSPORTE: motor=1; start=0 → PARADO; else garrafa=1 → ENCHENDO (timer cleared).
- ENCHENDO: ev=1, timer+1 per cycle; sensor_de_nivel=1 → VEDANDO if rolhas_linha>0 else AGUARDA_ROLHA; sensor has priority over timeout; timer==TIMEOUT-1 with sensor=0 → FALHA.
- AGUARDA_ROLHA: alarme=1 when rolhas_estoque==0; rolhas_linha>0 → VEDANDO.
- VEDANDO: ve=1 exactly one cycle; rolhas_linha−1 at exit edge; → CQ.
- CQ: estaemcq=1, motor=0; cq_valido=1 → CONTANDO if cq_ok else DESCARTE.
- DESCARTE: descarte=1 one cycle; → TRANSPORTE; no counter change.
- CONTANDO: one cycle; garrafas==LOTE-1 → garrafas=0, lotes+1 (lotes==MAX_LOTES-1 → 0), lote_pronto=1; else garrafas+1; → TRANSPORTE.
- FALHA: falha=1, all actuators 0; sticky; start=0 → PARADO only.
- Dispenser (independent of FSM, except disabled in reset): disp = rolhas_linha<LINHA_CAP && rolhas_estoque>0; on disp, estoque−1, linha+1.
- Simultaneous seal and dispense: linha unchanged, estoque−1.
- Restock: estoque + RECARGA (− 1 if disp same cycle), saturating at 2^W−1.
- No counter ever underflows; linha never exceeds LINHA_CAP.

## Timing
- Reset (reset=0 at edge): state PARADO; estoque=ESTQ_INICIAL; linha, garrafas, lotes=0; all 1-bit outputs 0 (disp forced 0 while reset=0).
- Every input takes effect at the next rising edge; state outputs valid one cycle after the causing input.
- Good bottle, inputs ready: garrafa edge → ENCHENDO; nivel edge → VEDANDO; +1 → CQ; cq_valido edge → CONTANDO; +1 → TRANSPORTE with garrafas updated.
- lote_pronto high during the CONTANDO cycle only.
- Reset asserted mid-operation overrides everything that edge, including restock.

## Test plan
- Reset with default params → estoque=20, linha=0; after 5 cycles of reset=1: linha=5, estoque=15, disp low from then on.
- 12 good bottles → garrafas 0..11 then 0, lotes=1, one lote_pronto pulse; 120 bottles → lotes wraps to 0.
- cq_ok=0 → descarte high one cycle, garrafas unchanged, returns to TRANSPORTE.
- Hold sensor_de_nivel=0 in ENCHENDO → FALHA after exactly 16 cycles of ev; start=0 → PARADO.
- Stock 0, linha 0 at fill done → AGUARDA_ROLHA with alarme=1; add_estoque → estoque=10, next cycle disp, then VEDANDO.
- Seal and dispense same cycle with add_estoque at estoque=250 → linha unchanged, estoque=255 (saturated).
